ret_stack_sequencer: RTL

- Initiator side of the return-address stack interface: the sequencer that issues push/pop commands to the stack file and consumes its return address and error flag.
- Sits between instruction decode and the PC register. Turns decoded call/return requests into single-cycle stack operations and a PC load.
- Keeps a shadow depth count so that overflow and underflow are trapped before a stack operation is issued.

---
 rtl/ret_stack_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ret_stack_sequencer.sv
// Return-address stack sequencer: turns decoded call/return requests into
// single-cycle push/pop strobes and a PC load, trapping overflow/underflow.
module ret_stack_sequencer #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 13,
  parameter int DEPTH_W = 7
) (
  input  logic               Slow_Clock,
  input  logic               Reset,
  input  logic               Call_Req,
  input  logic               Ret_Req,
  input  logic [ADDR_W-1:0]  Cur_PC,
  input  logic [ADDR_W-1:0]  Call_Target,
  input  logic [ADDR_W-1:0]  Ret_Add,
  input  logic               Stack_Err,
  output logic               Stack_Enable,
  output logic               Stack_Write,
  output logic [ADDR_W-1:0]  NPPC,
  output logic [ADDR_W-1:0]  Next_PC,
  output logic               PC_Load,
  output logic               Busy,
  output logic               Trap,
  output logic [1:0]         Trap_Code,
  output logic [DEPTH_W-1:0] Depth
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_LOAD = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [ADDR_W-1:0]   nppc_q, nppc_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]   next_pc_q, next_pc_d;
  logic [1:0]          trap_code_q, trap_code_d;
  logic                stack_en_q, stack_en_d;
  logic                stack_wr_q, stack_wr_d;
  logic                pc_load_q, pc_load_d;
  logic                busy_q, busy_d;
  logic                trap_q, trap_d;

  // State and datapath registers
  always_ff @(posedge Slow_Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      nppc_q      <= '0;
      target_q    <= '0;
      next_pc_q   <= '0;
      trap_code_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      nppc_q      <= nppc_d;
      target_q    <= target_d;
      next_pc_q   <= next_pc_d;
      trap_code_q <= trap_code_d;
    end
  end

  // Next-state and datapath update; request checks are prioritised in IDLE
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    nppc_d      = nppc_q;
    target_d    = target_q;
    next_pc_d   = next_pc_q;
    trap_code_d = trap_code_q;
    case (state_q)
      S_IDLE: begin
        if (Call_Req && Ret_Req) begin
          state_d     = S_TRAP;
          trap_code_d = 2'd3;
        end else if (Call_Req) begin
          if (depth_q == DEPTH_FULL) begin
            state_d     = S_TRAP;
            trap_code_d = 2'd1;
          end else begin
            nppc_d   = Cur_PC + ADDR_W'(1);
            target_d = Call_Target;
            state_d  = S_PUSH;
          end
        end else if (Ret_Req) begin
          if (depth_q == DEPTH_W'(0)) begin
            state_d     = S_TRAP;
            trap_code_d = 2'd2;
          end else begin
            state_d = S_POP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        if (Stack_Err) begin
          state_d     = S_TRAP;
          trap_code_d = 2'd1;
        end else begin
          depth_d   = depth_q + DEPTH_W'(1);
          next_pc_d = target_q;
          state_d   = S_LOAD;
        end
      end
      S_POP: begin
        if (Stack_Err) begin
          state_d     = S_TRAP;
          trap_code_d = 2'd2;
        end else begin
          depth_d   = depth_q - DEPTH_W'(1);
          next_pc_d = Ret_Add;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the next state so they register in step with it
  always_comb begin
    stack_en_d = 1'b0;
    stack_wr_d = 1'b0;
    pc_load_d  = 1'b0;
    busy_d     = 1'b1;
    trap_d     = 1'b0;
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_PUSH: begin
        stack_en_d = 1'b1;
        stack_wr_d = 1'b1;
      end
      S_POP:   stack_en_d = 1'b1;
      S_LOAD:  pc_load_d  = 1'b1;
      S_TRAP:  trap_d     = 1'b1;
      default: busy_d     = 1'b1;
    endcase
  end

  // Control output registers; async reset drops the stack strobe immediately
  always_ff @(posedge Slow_Clock or negedge Reset) begin
    if (!Reset) begin
      stack_en_q <= 1'b0;
      stack_wr_q <= 1'b0;
      pc_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      stack_en_q <= stack_en_d;
      stack_wr_q <= stack_wr_d;
      pc_load_q  <= pc_load_d;
      busy_q     <= busy_d;
      trap_q     <= trap_d;
    end
  end

  assign Stack_Enable = stack_en_q;
  assign Stack_Write  = stack_wr_q;
  assign NPPC         = nppc_q;
  assign Next_PC      = next_pc_q;
  assign PC_Load      = pc_load_q;
  assign Busy         = busy_q;
  assign Trap         = trap_q;
  assign Trap_Code    = trap_code_q;
  assign Depth        = depth_q;

endmodule
